// File: rtl/operand_stream_loader_if.sv
// Stream bundle for operand_stream_loader: operand beats in, captured sum out.
// master = producer/consumer side, slave = loader side.
interface operand_stream_loader_if #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned SUM_W = 11
);
  logic             in_valid;
  logic [OP_W-1:0]  in_data;
  logic             in_last;
  logic             in_ready;
  logic [SUM_W-1:0] result;
  logic             result_valid;
  logic             result_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output result_ready,
    input  in_ready,
    input  result,
    input  result_valid
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  result_ready,
    output in_ready,
    output result,
    output result_valid
  );
endinterface

// File: rtl/operand_stream_loader.sv
// Serial front end for the parallel adder: assembles operand beats into a flat bus, captures the sum.
// Optional LOADER_CHECK_EN builds a running accumulator that flags sum mismatches in check_err_o.
module operand_stream_loader #(
  parameter int unsigned N_OPS = 128,
  parameter int unsigned OP_W  = 4,
  parameter int unsigned SUM_W = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  operand_stream_loader_if.slave   stream_io,
  output logic [N_OPS*OP_W-1:0]    ops_flat_o,
  output logic                     ops_valid_o,
  input  logic [SUM_W-1:0]         sum_in_i,
  output logic                     check_err_o
);

  localparam int unsigned CntW = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam logic [CntW-1:0] LastSlot = CntW'(N_OPS - 1);

  typedef enum logic [1:0] {
    StFill,
    StSettle,
    StResult
  } state_e;

  state_e                           state_q, state_d;
  logic [CntW-1:0]                  cnt_q, cnt_d;
  logic [N_OPS-1:0][OP_W-1:0]       ops_q, ops_d;
  logic [SUM_W-1:0]                 result_q, result_d;
  logic                             accept;
  logic                             first_beat;

  // in_ready is a pure function of state, so no in_valid -> in_ready path exists.
  assign accept     = stream_io.in_valid && (state_q == StFill);
  assign first_beat = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ops_d    = ops_q;
    result_d = result_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          // The first beat wipes the previous frame so short frames zero-pad.
          if (first_beat) begin
            ops_d = '0;
          end
          ops_d[cnt_q] = stream_io.in_data;
          if (stream_io.in_last || (cnt_q == LastSlot)) begin
            state_d = StSettle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StSettle: begin
        result_d = sum_in_i;
        state_d  = StResult;
      end
      StResult: begin
        if (stream_io.result_ready) begin
          state_d = StFill;
        end
      end
      default: begin
        state_d = StFill;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFill;
      cnt_q    <= '0;
      ops_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ops_q    <= ops_d;
      result_q <= result_d;
    end
  end

  assign stream_io.in_ready     = (state_q == StFill);
  assign stream_io.result_valid = (state_q == StResult);
  assign stream_io.result       = result_q;
  assign ops_valid_o            = (state_q != StFill);
  assign ops_flat_o             = ops_q;

`ifdef LOADER_CHECK_EN
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             err_q, err_d;

  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    if (accept) begin
      acc_d = (first_beat ? '0 : acc_q) + SUM_W'(stream_io.in_data);
    end
    // Comparing against sum_in_i in SETTLE matches result_q on entry to RESULT.
    if ((state_q == StSettle) && (acc_q != sum_in_i)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end

  assign check_err_o = err_q;
`else
  assign check_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_operand_stream_loader.sv
// Scoreboard bench for operand_stream_loader: driver pushes expected frames, a negedge monitor checks.
module tb_operand_stream_loader;
  localparam int N = 128;
  localparam int W = 4;
  localparam int S = 11;
`ifdef LOADER_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_stream_loader_if #(.OP_W(W), .SUM_W(S)) bus ();

  logic [N*W-1:0] ops_flat;
  logic           ops_valid;
  logic [S-1:0]   sum_in;
  logic           check_err;

  operand_stream_loader #(.N_OPS(N), .OP_W(W), .SUM_W(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .stream_io   (bus),
    .ops_flat_o  (ops_flat),
    .ops_valid_o (ops_valid),
    .sum_in_i    (sum_in),
    .check_err_o (check_err)
  );

  int corrupt = 0;
  int stall   = 0;
  bit rr_rand = 1'b0;

  // Behavioural adder: plain sum of the slots, optionally perturbed.
  always_comb begin
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(ops_flat[k*W +: W]);
    sum_in = S'(s + corrupt);
  end

  typedef struct {
    logic [S-1:0]   sum;
    logic [N*W-1:0] ops;
    bit             corrupt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   err_model = 1'b0;
  int   pushed = 0;
  int   popped = 0;

  task automatic check(input string name, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic finish_now();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Consumer: honours a requested stall count, otherwise ready high or random.
  initial begin
    bus.result_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.result_valid && stall > 0) begin
        bus.result_ready = 1'b0;
        stall--;
      end else if (rr_rand) begin
        bus.result_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.result_ready = 1'b1;
      end
    end
  end

  // Monitor
  int   ncyc  = 0;
  int   beats = 0;
  int   end_n = -100;
  bit   seen  = 1'b0;
  bit   acc_pend = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      beats    = 0;
      seen     = 1'b0;
      acc_pend = 1'b0;
      end_n    = -100;
    end else begin
      if (acc_pend) begin
        check("release_in_ready", bus.in_ready, 1);
        check("release_result_valid", bus.result_valid, 0);
        check("release_ops_valid", ops_valid, 0);
        check("release_ops_hold", ops_flat, cur.ops);
        acc_pend = 1'b0;
      end
      if (ncyc == end_n + 1) begin
        check("settle_ops_valid", ops_valid, 1);
        check("settle_in_ready", bus.in_ready, 0);
        check("settle_result_valid", bus.result_valid, 0);
      end
      if (bus.result_valid === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got result %0d expected no frame", bus.result);
          end else begin
            cur = sb.pop_front();
            popped++;
            err_model = err_model | (CheckEn & cur.corrupt);
            check("result", bus.result, cur.sum);
            check("ops_flat", ops_flat, cur.ops);
            check("result_latency", ncyc - end_n, 2);
            check("check_err", check_err, err_model);
          end
        end else begin
          check("frozen_result", bus.result, cur.sum);
          check("frozen_ops_flat", ops_flat, cur.ops);
          check("frozen_in_ready", bus.in_ready, 0);
          check("frozen_ops_valid", ops_valid, 1);
        end
        if (bus.result_ready) begin
          acc_pend = 1'b1;
          seen     = 1'b0;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        beats++;
        if (bus.in_last || beats == N) begin
          end_n = ncyc;
          beats = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic last);
    int k;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    k = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      k++;
      if (k > 3000) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: got in_ready 0 expected 1 within 3000 cycles");
        finish_now();
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.in_ready === 1'b1 && sb.size() == 0 && !acc_pend) && k < 3000);
    if (k >= 3000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got %0d pending frames expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_ops_valid"}, ops_valid, 0);
    check({tag, "_result_valid"}, bus.result_valid, 0);
    check({tag, "_result"}, bus.result, 0);
    check({tag, "_ops_flat"}, ops_flat, 0);
    check({tag, "_check_err"}, check_err, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    err_model = 1'b0;
    stall     = 0;
    sb.delete();
    @(negedge clk);
    check_reset_values(tag);
    @(posedge clk);
    #1;
  endtask

  typedef logic [W-1:0] nib_q_t[$];

  task automatic send_frame(input nib_q_t q, input int c, input int s, input bit gaps,
                            input bit last_on_full);
    exp_t e;
    int   total;
    wait_idle();
    corrupt = c;
    stall   = s;
    e.ops   = '0;
    total   = 0;
    for (int i = 0; i < q.size(); i++) begin
      e.ops[i*W +: W] = q[i];
      total += int'(q[i]);
    end
    e.sum     = S'(total + c);
    e.corrupt = (c != 0);
    sb.push_back(e);
    pushed++;
    for (int i = 0; i < q.size(); i++) begin
      send_beat(q[i], (i == q.size() - 1) && (q.size() < N || last_on_full));
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    nib_q_t q;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    do_reset("reset");

    // 6x15 + 122x1, frame ended by the counter
    q.delete();
    for (int i = 0; i < N; i++) q.push_back((i < 6) ? 4'd15 : 4'd1);
    send_frame(q, 0, 0, 1'b0, 1'b0);

    // Maximum sum with consumer stalled
    q.delete();
    for (int i = 0; i < N; i++) q.push_back(4'd15);
    send_frame(q, 0, 5, 1'b0, 1'b1);

    // Short frame after a full one
    q.delete();
    q.push_back(4'd5);
    q.push_back(4'd6);
    q.push_back(4'd7);
    send_frame(q, 0, 0, 1'b0, 1'b0);

    // Abort after 40 beats
    wait_idle();
    for (int i = 0; i < 40; i++) send_beat(4'($urandom_range(1, 15)), 1'b0);
    do_reset("abort");
    q.delete();
    for (int i = 0; i < N; i++) q.push_back(4'd1);
    send_frame(q, 0, 0, 1'b0, 1'b0);

    // Adder returns a wrong sum
    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(4'd2);
    send_frame(q, 1, 0, 1'b0, 1'b0);

    // Random frames with gaps and a random consumer
    rr_rand = 1'b1;
    for (int f = 0; f < 8; f++) begin
      int len;
      q.delete();
      len = (f % 3 == 0) ? N : $urandom_range(1, N);
      for (int i = 0; i < len; i++) q.push_back(4'($urandom_range(0, 15)));
      send_frame(q, 0, 0, 1'b1, 1'($urandom_range(0, 1)));
    end

    wait_idle();
    check("frames_returned", popped, pushed);
    finish_now();
  end

  initial begin
    #2000000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no completion expected finish within 2 ms");
    finish_now();
  end

endmodule
